spi_cmd_queue: RTL and testbench
================================

SPI_CMD_QUEUE -- requirements
Module: spi_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 8, command FIFO entries (power of two, 2..64).
REQ-002 Parameter BUSY_TIMEOUT, default 255, max sys_clk cycles waited for busy to rise after a request pulse.
REQ-003 sys_clk  in  1  system clock, 50 MHz, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high; clock sys_clk.
REQ-005 cmd_valid  in  1  host command offered.
REQ-006 cmd_ready  out  1  queue can accept; transfer when cmd_valid&cmd_ready.
REQ-007 cmd_type  in  2  00 DAC write, 01 ADC write, 10 ADC read, 11 reserved.
REQ-008 cmd_addr  in  16  DAC: [4:0] used; ADC: [15:13] chip, [12:0] register.
REQ-009 cmd_data  in  12  DAC: [11:0]; ADC write: [7:0].
REQ-010 dac_request_write, adc_request_write, adc_request_read  out  1 each  request pulses to SPI controller.
REQ-011 dac_address  out  5;  dac_data  out  12;  adc_address  out  16;  adc_data  out  8  held stable from ISSUE until IDLE.
REQ-012 busy  in  1  SPI controller busy.
REQ-013 adc_data_readback  in  8  controller readback byte.
REQ-014 rd_valid  out  1  one-cycle pulse, readback result valid.
REQ-015 rd_addr  out  16;  rd_data  out  8  address and byte of completed ADC read.
REQ-016 fifo_level  out  log2(DEPTH)+1  entries currently queued.
REQ-017 err_timeout  out  1  sticky timeout flag;  err_clear  in  1  clears err_timeout.

Function
REQ-018 FIFO SHALL store {cmd_type, cmd_addr, cmd_data}; cmd_ready = (fifo_level != DEPTH); write and read in same cycle SHALL leave level unchanged, including when full.
REQ-019 cmd_type 11 SHALL be accepted and discarded at pop without any request pulse.
REQ-020 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESULT.
REQ-021 IDLE: FIFO non-empty and busy low -> pop head into output registers, go ISSUE; otherwise stay.
REQ-022 ISSUE: exactly one request output high for exactly one cycle, selected by cmd_type; go WAIT_BUSY.
REQ-023 WAIT_BUSY: all request outputs low; busy high -> WAIT_DONE; counter reaches BUSY_TIMEOUT with busy low -> set err_timeout, go IDLE, command dropped, no rd_valid.
REQ-024 WAIT_DONE: stay while busy high; busy low -> RESULT if ADC read else IDLE.
REQ-025 RESULT: rd_data <= adc_data_readback sampled this cycle, rd_addr <= stored address, rd_valid high one cycle; go IDLE.
REQ-026 Request pulse to next request pulse SHALL be at least 4 cycles apart; no request SHALL be issued while busy high.
REQ-027 Request outputs SHALL never be high in the same cycle as each other.
REQ-028 err_clear and timeout in the same cycle: set wins.
REQ-029 Timeout counter width ceil(log2(BUSY_TIMEOUT+1)), cleared on entry to WAIT_BUSY; no wrap.
REQ-030 FIFO pointers wrap modulo DEPTH without loss.

Reset
REQ-031 On reset: FSM IDLE, FIFO empty, fifo_level 0, cmd_ready 1, all request outputs 0, rd_valid 0, rd_data 0, rd_addr 0, address/data outputs 0, err_timeout 0.
REQ-032 Reset mid-transaction SHALL abort immediately; queued commands lost; no request pulse in the first cycle after deassertion.

Verification
REQ-033 Push DAC write addr 0x13 data 0xABC; busy model rises 2 cycles after pulse, 40 cycles high -> one dac_request_write pulse, dac_address 0x13, dac_data 0xABC, no rd_valid.
REQ-034 Push ADC read addr 0x2005; model returns 0x5A at busy fall -> adc_request_read once, rd_valid one cycle, rd_addr 0x2005, rd_data 0x5A.
REQ-035 Push 9 commands back-to-back with busy held high -> cmd_ready low after 8th, fifo_level 8; release busy -> all 8 issued in order, 9th accepted when level drops.
REQ-036 Busy never rises after pulse -> err_timeout set after 255 cycles, next command issued; err_clear -> err_timeout 0.
REQ-037 Push cmd_type 11 then ADC write addr 0xE0FF data 0x7F -> only adc_request_write pulse, adc_address 0xE0FF, adc_data 0x7F.
REQ-038 Assert reset during WAIT_DONE with 3 queued -> all outputs at reset values, fifo_level 0, no pulse after release.

Source files
------------

// File: rtl/spi_cmd_queue.sv
`timescale 1ns/1ps

// spi_cmd_queue_fifo: generic circular FIFO with an occupancy count.
// Latency: a write is readable the cycle after it is accepted; the read data path is combinational.
// Backpressure: o_wr_rdy drops at DEPTH entries; o_rd_vld drops when empty.
module spi_cmd_queue_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 30
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   i_wr_vld,
  output logic                   o_wr_rdy,
  input  logic [WIDTH-1:0]       i_wr_dat,
  input  logic                   i_rd_rdy,
  output logic                   o_rd_vld,
  output logic [WIDTH-1:0]       o_rd_dat,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_wr_rdy = (r_level != LW'(DEPTH));
  assign o_rd_vld = (r_level != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_level  = r_level;
  assign w_push   = i_wr_vld & o_wr_rdy;
  assign w_pop    = i_rd_rdy & o_rd_vld;

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  // Pointers wrap modulo DEPTH on their own since DEPTH is a power of two; push+pop keeps the level.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// spi_cmd_queue: queues host DAC/ADC commands and hands them one at a time to the SPI controller.
// Latency: a head command with busy low pops in one cycle and pulses its request the next cycle.
// Backpressure: cmd_ready low while DEPTH commands are queued; nothing issues while busy is high.
module spi_cmd_queue #(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_type,
  input  logic [15:0]            cmd_addr,
  input  logic [11:0]            cmd_data,
  output logic                   dac_request_write,
  output logic                   adc_request_write,
  output logic                   adc_request_read,
  output logic [4:0]             dac_address,
  output logic [11:0]            dac_data,
  output logic [15:0]            adc_address,
  output logic [7:0]             adc_data,
  input  logic                   busy,
  input  logic [7:0]             adc_data_readback,
  output logic                   rd_valid,
  output logic [15:0]            rd_addr,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   err_timeout,
  input  logic                   err_clear
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] CMD_DAC_WR = 2'b00;
  localparam logic [1:0] CMD_ADC_WR = 2'b01;
  localparam logic [1:0] CMD_ADC_RD = 2'b10;
  localparam logic [1:0] CMD_RSVD   = 2'b11;

  typedef struct packed {
    logic [1:0]  typ;
    logic [15:0] addr;
    logic [11:0] dat;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  cmd_t          w_cmd_in;
  cmd_t          w_head;
  logic          w_head_vld;
  logic          w_pop;
  logic          w_load;
  logic          w_timeout;
  logic          w_req_dac_wr;
  logic          w_req_adc_wr;
  logic          w_req_adc_rd;
  logic [1:0]    r_type;
  logic [4:0]    r_dac_addr;
  logic [11:0]   r_dac_dat;
  logic [15:0]   r_adc_addr;
  logic [7:0]    r_adc_dat;
  logic [TW-1:0] r_cnt;
  logic          r_rd_vld;
  logic [15:0]   r_rd_addr;
  logic [7:0]    r_rd_dat;
  logic          r_err;

  assign w_cmd_in = '{typ: cmd_type, addr: cmd_addr, dat: cmd_data};

  spi_cmd_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .i_wr_vld (cmd_valid),
    .o_wr_rdy (cmd_ready),
    .i_wr_dat (w_cmd_in),
    .i_rd_rdy (w_pop),
    .o_rd_vld (w_head_vld),
    .o_rd_dat (w_head),
    .o_level  (fifo_level)
  );

  // Sequencer state register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the single-cycle request strobes; reserved commands are popped and dropped in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_timeout    = 1'b0;
    w_req_dac_wr = 1'b0;
    w_req_adc_wr = 1'b0;
    w_req_adc_rd = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_head_vld && !busy) begin
          w_pop = 1'b1;
          if (w_head.typ != CMD_RSVD) begin
            w_load      = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        case (r_type)
          CMD_DAC_WR: w_req_dac_wr = 1'b1;
          CMD_ADC_WR: w_req_adc_wr = 1'b1;
          CMD_ADC_RD: w_req_adc_rd = 1'b1;
          default:    ;
        endcase
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == TW'(BUSY_TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          w_state_nxt = (r_type == CMD_ADC_RD) ? S_RESULT : S_IDLE;
        end
      end
      S_RESULT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture the popped command; each controller-facing field holds until the next command of its kind.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_type     <= CMD_DAC_WR;
      r_dac_addr <= '0;
      r_dac_dat  <= '0;
      r_adc_addr <= '0;
      r_adc_dat  <= '0;
    end else if (w_load) begin
      r_type <= w_head.typ;
      if (w_head.typ == CMD_DAC_WR) begin
        r_dac_addr <= w_head.addr[4:0];
        r_dac_dat  <= w_head.dat;
      end else begin
        r_adc_addr <= w_head.addr;
        r_adc_dat  <= w_head.dat[7:0];
      end
    end
  end

  // Busy-rise timer: zeroed while the request is out, saturates at BUSY_TIMEOUT.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT_BUSY && r_cnt != TW'(BUSY_TIMEOUT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Readback capture; rd_valid is aligned with the newly registered rd_addr/rd_data.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_rd_vld  <= 1'b0;
      r_rd_addr <= '0;
      r_rd_dat  <= '0;
    end else begin
      r_rd_vld <= (r_state == S_RESULT);
      if (r_state == S_RESULT) begin
        r_rd_addr <= r_adc_addr;
        r_rd_dat  <= adc_data_readback;
      end
    end
  end

  // Sticky timeout flag; a new timeout outranks a simultaneous clear.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (err_clear) begin
      r_err <= 1'b0;
    end
  end

  assign dac_request_write = w_req_dac_wr;
  assign adc_request_write = w_req_adc_wr;
  assign adc_request_read  = w_req_adc_rd;
  assign dac_address       = r_dac_addr;
  assign dac_data          = r_dac_dat;
  assign adc_address       = r_adc_addr;
  assign adc_data          = r_adc_dat;
  assign rd_valid          = r_rd_vld;
  assign rd_addr           = r_rd_addr;
  assign rd_data           = r_rd_dat;
  assign err_timeout       = r_err;

  // At most one request strobe per cycle, and the queue never overfills.
  a_req_onehot: assert property (@(posedge sys_clk) disable iff (reset)
    $onehot0({dac_request_write, adc_request_write, adc_request_read}));
  a_level_bound: assert property (@(posedge sys_clk) disable iff (reset)
    fifo_level <= LW'(DEPTH));
endmodule

// File: tb/tb_spi_cmd_queue.sv
`timescale 1ns/1ps

// tb_spi_cmd_queue: randomized and directed bench with a transaction-level queue model.
// Latency: not applicable.
// Backpressure: the bench SPI controller model answers requests with programmable busy timing.
module tb_spi_cmd_queue;
  localparam int DEPTH        = 8;
  localparam int BUSY_TIMEOUT = 255;
  localparam int LW           = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0]  t;
    logic [15:0] a;
    logic [11:0] d;
  } cmd_s;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_type;
  logic [15:0]   cmd_addr;
  logic [11:0]   cmd_data;
  logic          dac_request_write, adc_request_write, adc_request_read;
  logic [4:0]    dac_address;
  logic [11:0]   dac_data;
  logic [15:0]   adc_address;
  logic [7:0]    adc_data;
  logic          busy;
  logic [7:0]    adc_data_readback;
  logic          rd_valid;
  logic [15:0]   rd_addr;
  logic [7:0]    rd_data;
  logic [LW-1:0] fifo_level;
  logic          err_timeout;
  logic          err_clear;

  logic busy_auto, busy_man, resp_active;
  int   resp_mode;               // 0: auto responder, 1: never answers, 2: bench drives busy_man
  logic rnd_resp;
  int   fix_delay, fix_hold;
  logic [7:0] fix_rb, exp_rb;

  cmd_s exp_q[$];
  logic exp_rd_pending;
  logic [15:0] exp_rd_addr;
  int n_tests = 0, n_fail = 0;
  int n_pulses = 0, n_dac = 0, n_awr = 0, n_ard = 0, n_rdv = 0;
  int cyc = 0, last_cyc = 0;
  logic have_last, prev_req, prev_rdv;

  assign busy = busy_auto | busy_man;

  spi_cmd_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .dac_request_write(dac_request_write), .adc_request_write(adc_request_write),
    .adc_request_read(adc_request_read),
    .dac_address(dac_address), .dac_data(dac_data),
    .adc_address(adc_address), .adc_data(adc_data),
    .busy(busy), .adc_data_readback(adc_data_readback),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .fifo_level(fifo_level), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  initial forever #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected end well before", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller model: busy rises some cycles after a request, stays high, then falls with the readback byte.
  initial begin
    int dly, hld;
    logic [7:0] rb;
    busy_auto = 1'b0; resp_active = 1'b0; adc_data_readback = 8'h00; exp_rb = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (!reset && resp_mode == 0 && (dac_request_write || adc_request_write || adc_request_read)) begin
        resp_active = 1'b1;
        dly = rnd_resp ? int'($urandom_range(1, 4)) : fix_delay;
        hld = rnd_resp ? int'($urandom_range(1, 12)) : fix_hold;
        rb  = rnd_resp ? 8'($urandom) : fix_rb;
        repeat (dly) @(negedge sys_clk);
        #1 busy_auto = 1'b1;
        repeat (hld) @(negedge sys_clk);
        #1 busy_auto = 1'b0;
        adc_data_readback = rb;
        exp_rb = rb;
        resp_active = 1'b0;
      end
    end
  end

  // Monitor: every request must match the next queued non-reserved command, in order.
  always @(negedge sys_clk) begin
    logic [2:0] req_v;
    logic [1:0] got_t;
    cmd_s e;
    if (reset) begin
      have_last = 1'b0; prev_req = 1'b0; prev_rdv = 1'b0;
    end else begin
      req_v = {dac_request_write, adc_request_write, adc_request_read};
      if (req_v != 3'b000) begin
        n_pulses++;
        chk("req_single", $countones(req_v), 1);
        chk("req_one_cycle", prev_req, 1'b0);
        chk("req_busy_low", busy, 1'b0);
        if (have_last) chk("req_spacing_ge4", (cyc - last_cyc) >= 4, 1'b1);
        have_last = 1'b1; last_cyc = cyc;
        got_t = dac_request_write ? 2'b00 : (adc_request_write ? 2'b01 : 2'b10);
        if (dac_request_write) n_dac++;
        if (adc_request_write) n_awr++;
        if (adc_request_read)  n_ard++;
        chk("req_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("req_type", got_t, e.t);
          if (e.t == 2'b00) begin
            chk("dac_address", dac_address, e.a[4:0]);
            chk("dac_data", dac_data, e.d);
          end else begin
            chk("adc_address", adc_address, e.a);
            if (e.t == 2'b01) chk("adc_data", adc_data, e.d[7:0]);
            if (e.t == 2'b10) begin
              exp_rd_pending = 1'b1;
              exp_rd_addr = e.a;
            end
          end
        end
      end
      prev_req = (req_v != 3'b000);
      if (rd_valid) begin
        n_rdv++;
        chk("rd_one_cycle", prev_rdv, 1'b0);
        chk("rd_expected", exp_rd_pending, 1'b1);
        chk("rd_addr", rd_addr, exp_rd_addr);
        chk("rd_data", rd_data, exp_rb);
        exp_rd_pending = 1'b0;
      end
      prev_rdv = rd_valid;
    end
  end

  task automatic push(input logic [1:0] t, input logic [15:0] a, input logic [11:0] d);
    int n;
    n = 0;
    @(negedge sys_clk);
    cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("push_accepted", cmd_ready, 1'b1);
    if (cmd_ready) begin
      @(posedge sys_clk);
      if (t != 2'b11) exp_q.push_back('{t: t, a: a, d: d});
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n, quiet;
    n = 0; quiet = 0;
    while (quiet < 8 && n < 6000) begin
      @(negedge sys_clk);
      n++;
      if (exp_q.size() == 0 && !exp_rd_pending && !busy && fifo_level == 0 && !resp_active) quiet++;
      else quiet = 0;
    end
    chk("drain_done", quiet >= 8, 1'b1);
  endtask

  task automatic check_reset_vals(input string w);
    chk({w, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({w, "_fifo_level"}, fifo_level, 0);
    chk({w, "_requests"}, {dac_request_write, adc_request_write, adc_request_read}, 3'b000);
    chk({w, "_rd_valid"}, rd_valid, 1'b0);
    chk({w, "_rd_data"}, rd_data, 0);
    chk({w, "_rd_addr"}, rd_addr, 0);
    chk({w, "_dac_address"}, dac_address, 0);
    chk({w, "_dac_data"}, dac_data, 0);
    chk({w, "_adc_address"}, adc_address, 0);
    chk({w, "_adc_data"}, adc_data, 0);
    chk({w, "_err_timeout"}, err_timeout, 1'b0);
  endtask

  initial begin
    int p0, d0, a0, r0, k, exp_cnt;
    logic [1:0] t;
    reset = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_addr = 16'h0; cmd_data = 12'h0;
    err_clear = 1'b0; busy_man = 1'b0; resp_mode = 0; rnd_resp = 1'b0;
    fix_delay = 2; fix_hold = 40; fix_rb = 8'h00; exp_rd_pending = 1'b0; exp_rd_addr = 16'h0;
    repeat (3) @(negedge sys_clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge sys_clk);
    check_reset_vals("after_reset");

    // Single DAC write, busy 2 cycles after the pulse for 40 cycles.
    p0 = n_pulses; d0 = n_dac; r0 = n_rdv;
    push(2'b00, 16'h0013, 12'hABC);
    drain();
    chk("dac_wr_pulses", n_dac - d0, 1);
    chk("dac_wr_total", n_pulses - p0, 1);
    chk("dac_wr_no_rd", n_rdv - r0, 0);
    chk("dac_wr_address", dac_address, 5'h13);
    chk("dac_wr_data", dac_data, 12'hABC);

    // Single ADC read returning 0x5A.
    fix_hold = 6; fix_rb = 8'h5A;
    p0 = n_pulses; a0 = n_ard; r0 = n_rdv;
    push(2'b10, 16'h2005, 12'h000);
    drain();
    chk("adc_rd_pulses", n_ard - a0, 1);
    chk("adc_rd_total", n_pulses - p0, 1);
    chk("adc_rd_valids", n_rdv - r0, 1);
    chk("adc_rd_addr", rd_addr, 16'h2005);
    chk("adc_rd_data", rd_data, 8'h5A);

    // Fill with busy held high: 8 queue, 9th waits until the first pop.
    resp_mode = 2;
    @(negedge sys_clk); #1 busy_man = 1'b1;
    p0 = n_pulses;
    for (int i = 0; i < 8; i++) push(2'($urandom_range(0, 2)), 16'($urandom), 12'($urandom));
    chk("full_level", fifo_level, 8);
    chk("full_cmd_ready", cmd_ready, 1'b0);
    repeat (3) @(negedge sys_clk);
    chk("full_no_issue", n_pulses - p0, 0);
    fork
      push(2'b00, 16'h0009, 12'h999);
      begin
        repeat (4) @(negedge sys_clk);
        chk("full_9th_blocked", fifo_level, 8);
        #1 resp_mode = 0; busy_man = 1'b0;
      end
    join
    drain();
    chk("full_all_issued", n_pulses - p0, 9);

    // Busy never rises: timeout, next command still served, sticky until cleared.
    resp_mode = 1;
    p0 = n_pulses;
    push(2'b00, 16'h0001, 12'h111);
    k = 0;
    while (!dac_request_write && k < 50) begin
      @(negedge sys_clk);
      k++;
    end
    chk("to_first_pulse", dac_request_write, 1'b1);
    fork
      push(2'b00, 16'h0002, 12'h222);
      begin
        k = 0;
        while (!err_timeout && k < 400) begin
          @(negedge sys_clk);
          k++;
        end
        resp_mode = 0;
      end
    join
    chk("to_window", (k >= BUSY_TIMEOUT) && (k <= BUSY_TIMEOUT + 5), 1'b1);
    drain();
    chk("to_next_issued", n_pulses - p0, 2);
    chk("to_sticky", err_timeout, 1'b1);
    @(negedge sys_clk); err_clear = 1'b1;
    @(negedge sys_clk); err_clear = 1'b0;
    chk("to_cleared", err_timeout, 1'b0);

    // Timeout while err_clear is held: the set still shows for a cycle.
    resp_mode = 1; err_clear = 1'b1;
    push(2'b00, 16'h0003, 12'h333);
    k = 0;
    while (!err_timeout && k < 400) begin
      @(negedge sys_clk);
      k++;
    end
    chk("to_set_wins", err_timeout, 1'b1);
    @(negedge sys_clk);
    chk("to_clear_after", err_timeout, 1'b0);
    err_clear = 1'b0; resp_mode = 0;
    drain();

    // Reserved command dropped, ADC write behind it issues alone.
    p0 = n_pulses; a0 = n_awr;
    push(2'b11, 16'h1234, 12'h456);
    push(2'b01, 16'hE0FF, 12'h07F);
    drain();
    chk("rsvd_total", n_pulses - p0, 1);
    chk("rsvd_adc_wr", n_awr - a0, 1);
    chk("rsvd_adc_address", adc_address, 16'hE0FF);
    chk("rsvd_adc_data", adc_data, 8'h7F);

    // Reset during WAIT_DONE with three commands queued.
    resp_mode = 2;
    push(2'b01, 16'h4321, 12'h0A5);
    k = 0;
    while (!adc_request_write && k < 50) begin
      @(negedge sys_clk);
      k++;
    end
    chk("rst_pulse_seen", adc_request_write, 1'b1);
    #1 busy_man = 1'b1;
    for (int i = 0; i < 3; i++) push(2'b00, 16'($urandom), 12'($urandom));
    chk("rst_queued", fifo_level, 3);
    @(negedge sys_clk);
    reset = 1'b1; busy_man = 1'b0;
    exp_q.delete(); exp_rd_pending = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_reset_vals("mid_reset");
    reset = 1'b0; resp_mode = 0;
    p0 = n_pulses;
    @(negedge sys_clk);
    check_reset_vals("post_abort");
    repeat (20) @(negedge sys_clk);
    chk("rst_no_pulse", n_pulses - p0, 0);
    chk("rst_level", fifo_level, 0);

    // Random traffic against the queue model.
    rnd_resp = 1'b1;
    p0 = n_pulses; exp_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      t = 2'($urandom_range(0, 3));
      if (t != 2'b11) exp_cnt++;
      push(t, 16'($urandom), 12'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge sys_clk);
    end
    drain();
    chk("rand_issued", n_pulses - p0, exp_cnt);
    chk("rand_no_error", err_timeout, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
